// File: rtl/seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per clock, signed or
// unsigned per operation, valid/ready handshakes on both sides.
module seq_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out,
  output logic                 busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_reg;
  logic [WIDTH-1:0]     mcand_reg;
  logic [2*WIDTH-1:0]   acc_reg;
  logic [CW-1:0]        count_reg;
  logic                 neg_reg;
  logic [2*WIDTH-1:0]   out_reg;
  logic                 out_valid_reg;
  logic                 in_ready_reg;
  logic                 busy_reg;

  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_next;

  // The most-negative value negates to itself, which read as unsigned is its magnitude.
  always_comb begin
    a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
    b_mag = (is_signed && b[WIDTH-1]) ? -b : b;
  end

  // Upper half plus carry holds the partial product; the low half shifts the
  // multiplier out as the product bits shift in.
  always_comb begin
    sum      = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
    acc_next = {sum, acc_reg[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      mcand_reg     <= '0;
      acc_reg       <= '0;
      count_reg     <= '0;
      neg_reg       <= 1'b0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            mcand_reg    <= a_mag;
            acc_reg      <= {{WIDTH{1'b0}}, b_mag};
            neg_reg      <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            count_reg    <= '0;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            state_reg    <= CALC;
          end
        end
        CALC: begin
          acc_reg   <= acc_next;
          count_reg <= count_reg + 1'b1;
          if (count_reg == LAST) begin
            out_reg       <= neg_reg ? -acc_next : acc_next;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out       = out_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_seq_mul.sv
// Directed and randomized checks of seq_mul at WIDTH=8 and WIDTH=16 against an
// arithmetic reference product.
module tb_seq_mul;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv8, ir8, s8, ov8, ordy8, bz8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  logic        iv16, ir16, s16, ov16, ordy16, bz16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  seq_mul #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .is_signed(s8), .out_valid(ov8), .out_ready(ordy8), .out(p8), .busy(bz8)
  );

  seq_mul #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .is_signed(s16), .out_valid(ov16), .out_ready(ordy16), .out(p16), .busy(bz16)
  );

  // cur selects which instance the tasks drive and observe (0: WIDTH=8, 1: WIDTH=16)
  logic        cur;
  logic        ir_m, ov_m, bz_m;
  logic [31:0] out_m;
  assign ir_m  = cur ? ir16 : ir8;
  assign ov_m  = cur ? ov16 : ov8;
  assign bz_m  = cur ? bz16 : bz8;
  assign out_m = cur ? p16 : {16'h0, p8};

  int n_assert = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: interpret operands as integers, multiply, keep 2*w bits.
  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y,
                                          input logic s, input int w);
    longint xv, yv, p, m;
    m  = (64'sd1 <<< w) - 1;
    xv = longint'(x) & m;
    yv = longint'(y) & m;
    if (s && xv >= (64'sd1 <<< (w - 1))) xv -= (64'sd1 <<< w);
    if (s && yv >= (64'sd1 <<< (w - 1))) yv -= (64'sd1 <<< w);
    p = xv * yv;
    return 32'(p & ((64'sd1 <<< (2 * w)) - 1));
  endfunction

  task automatic drive(input logic v, input logic [15:0] x, input logic [15:0] y, input logic s);
    if (cur) begin iv16 = v; a16 = x; b16 = y; s16 = s; end
    else begin iv8 = v; a8 = x[7:0]; b8 = y[7:0]; s8 = s; end
  endtask

  task automatic set_ordy(input logic r);
    if (cur) ordy16 = r; else ordy8 = r;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, latency, product, optional stall, handshake.
  task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic s,
                        input int stall, input bit hold_valid, input string tag);
    int          w;
    int          lat;
    logic [31:0] exp;
    logic [31:0] held;
    w   = cur ? 16 : 8;
    exp = ref_mul(x, y, s, w);
    lat = 0;
    while (!ir_m && lat < 64) begin tick(); lat++; end
    check({tag, "_ready"}, 32'(ir_m), 32'd1);
    drive(1'b1, x, y, s);
    set_ordy(stall == 0);
    tick();
    if (!hold_valid) drive(1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
    check({tag, "_busy"}, 32'(bz_m), 32'd1);
    lat = 0;
    while (!ov_m && lat < 64) begin tick(); lat++; end
    check({tag, "_latency"}, 32'(lat), 32'(w));
    check({tag, "_product"}, out_m, exp);
    held = out_m;
    for (int i = 0; i < stall; i++) begin
      tick();
      check({tag, "_stall_valid"}, 32'(ov_m), 32'd1);
      check({tag, "_stall_out"}, out_m, held);
      check({tag, "_stall_inready"}, 32'(ir_m), 32'd0);
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    set_ordy(1'b1);
    tick();
    check({tag, "_post_valid"}, 32'(ov_m), 32'd0);
    check({tag, "_post_inready"}, 32'(ir_m), 32'd1);
    check({tag, "_post_out"}, out_m, held);
    $display("op %s w=%0d a=0x%0h b=0x%0h s=%0d stall=%0d lat=%0d out=0x%0h exp=0x%0h",
             tag, w, x, y, s, stall, lat, out_m, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    cur   = 1'b0;
    iv8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; ordy8 = 1'b1;
    iv16 = 1'b0; a16 = '0; b16 = '0; s16 = 1'b0; ordy16 = 1'b1;
    #13;
    check("rst_inready", 32'(ir8), 32'd1);
    check("rst_outvalid", 32'(ov8), 32'd0);
    check("rst_busy", 32'(bz8), 32'd0);
    check("rst_out", 32'(p8), 32'd0);
    check("rst_out16", p16, 32'd0);
    #10 rst_n = 1'b1;
    tick();

    // WIDTH=8 directed
    run_op(16'd255, 16'd255, 1'b0, 0, 1'b0, "u_max");
    check("u_max_const", out_m, 32'hFE01);
    run_op(16'h80, 16'h80, 1'b1, 0, 1'b0, "s_minmin");
    check("s_minmin_const", out_m, 32'h4000);
    run_op(16'h80, 16'h01, 1'b1, 0, 1'b0, "s_min_one");
    check("s_min_one_const", out_m, 32'hFF80);
    run_op(16'hFF, 16'h05, 1'b1, 0, 1'b0, "s_m1_5");
    check("s_m1_5_const", out_m, 32'hFFFB);
    run_op(16'h00, 16'hA5, 1'b0, 0, 1'b0, "u_zero_a");
    run_op(16'h80, 16'h00, 1'b1, 0, 1'b0, "s_zero_b");
    run_op(16'hFF, 16'h00, 1'b1, 0, 1'b0, "s_m1_zero");
    run_op(16'h00, 16'h81, 1'b0, 0, 1'b0, "u_zero_a2");
    run_op(16'd13, 16'd11, 1'b0, 0, 1'b0, "u_13_11");
    check("u_13_11_const", out_m, 32'd143);
    run_op(16'hC3, 16'h7E, 1'b1, 5, 1'b1, "backpressure");

    // Asynchronous reset during CALC
    drive(1'b1, 16'hFF, 16'hFF, 1'b0);
    tick();
    drive(1'b0, 16'h0, 16'h0, 1'b0);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_inready", 32'(ir8), 32'd1);
    check("mid_rst_outvalid", 32'(ov8), 32'd0);
    check("mid_rst_busy", 32'(bz8), 32'd0);
    check("mid_rst_out", 32'(p8), 32'd0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("post_rst_no_valid", 32'(ov8), 32'd0);
    end
    run_op(16'd3, 16'd7, 1'b0, 0, 1'b0, "after_rst");
    check("after_rst_const", out_m, 32'd21);

    // WIDTH=16 randomized
    cur = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] x;
      logic [15:0] y;
      x = 16'($urandom);
      y = 16'($urandom);
      if ($urandom_range(0, 15) == 0) x = 16'h8000;
      if ($urandom_range(0, 15) == 0) y = 16'hFFFF;
      run_op(x, y, 1'($urandom), $urandom_range(0, 3), 1'b0, "rnd16");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
